rgb_scaler: RTL and testbench



---
 rtl/rgb_scaler.sv | 196 +++++++++++++++++++
 tb/tb_rgb_scaler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_scaler.sv
// -----------------------------------------------------------------------------
// rgb_scaler
//
// Pipelined colour-depth converter. It widens three IN_W-bit colour channels
// to OUT_W bits. The scaling mode is sampled per pixel. Colour is forced to
// black outside the active region. hsync/vsync/active are delayed so they stay
// aligned with the scaled colour.
//
// Pipeline (every stage advances only on pix_en = 1):
//   S1  capture colours, syncs, active and scale_mode
//   S2  per-channel product x*N and the bit-replicated value
//   S3  divide by D, select by the captured mode, apply blanking, drive outputs
//
// Parameters:
//   IN_W   input bits per channel   (1..8)
//   OUT_W  output bits per channel  (IN_W..2*IN_W, at most 10)
//
// Ports:
//   clk_dot4x                      pipeline clock
//   rst                            asynchronous, active-high reset
//   pix_en                         pipeline advance strobe
//   scale_mode[1:0]                0 replicate, 1 rounded, 2 floor, 3 = as 0
//   red_i/green_i/blue_i[IN_W]     input colour
//   hsync_i/vsync_i/active_i       input timing
//   red_o/green_o/blue_o[OUT_W]    scaled colour (registered)
//   hsync_o/vsync_o/active_o       timing aligned to the colour (registered)
// -----------------------------------------------------------------------------
module rgb_scaler #(
    parameter int IN_W  = 6,
    parameter int OUT_W = 8
) (
    input  logic             clk_dot4x,
    input  logic             rst,
    input  logic             pix_en,
    input  logic [1:0]       scale_mode,
    input  logic [IN_W-1:0]  red_i,
    input  logic [IN_W-1:0]  green_i,
    input  logic [IN_W-1:0]  blue_i,
    input  logic             hsync_i,
    input  logic             vsync_i,
    input  logic             active_i,
    output logic [OUT_W-1:0] red_o,
    output logic [OUT_W-1:0] green_o,
    output logic [OUT_W-1:0] blue_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             active_o
);

    // Product width leaves one spare bit so x*N + floor(D/2) cannot overflow.
    localparam int PW = IN_W + OUT_W + 1;
    localparam logic [PW-1:0] D_VAL  = PW'((1 << IN_W) - 1);
    localparam logic [PW-1:0] N_VAL  = PW'((1 << OUT_W) - 1);
    localparam logic [PW-1:0] HALF_D = D_VAL >> 1;

    // x followed by its own top (OUT_W-IN_W) bits. The slice is taken from the
    // doubled word so OUT_W == IN_W needs no zero-width concatenation.
    function automatic logic [OUT_W-1:0] replicate(input logic [IN_W-1:0] x);
        logic [2*IN_W-1:0] dbl;
        dbl = {x, x};
        return OUT_W'(dbl >> (2*IN_W - OUT_W));
    endfunction

    // The divisor is a constant, so the divide reduces to fixed logic.
    function automatic logic [OUT_W-1:0] select_scaled(
        input logic [1:0]       mode,
        input logic [PW-1:0]    prod,
        input logic [OUT_W-1:0] rep
    );
        case (mode)
            2'd1:    return OUT_W'((prod + HALF_D) / D_VAL);
            2'd2:    return OUT_W'(prod / D_VAL);
            default: return rep;  // modes 0 and 3
        endcase
    endfunction

    // ---------------- stage registers ----------------
    logic [IN_W-1:0]  s1_col_q  [3];
    logic [IN_W-1:0]  s1_col_d  [3];
    logic             s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d, s1_act_q, s1_act_d;
    logic [1:0]       s1_mode_q, s1_mode_d;

    logic [PW-1:0]    s2_prod_q [3];
    logic [PW-1:0]    s2_prod_d [3];
    logic [OUT_W-1:0] s2_rep_q  [3];
    logic [OUT_W-1:0] s2_rep_d  [3];
    logic             s2_hs_q, s2_hs_d, s2_vs_q, s2_vs_d, s2_act_q, s2_act_d;
    logic [1:0]       s2_mode_q, s2_mode_d;

    logic [OUT_W-1:0] out_col_q [3];
    logic [OUT_W-1:0] out_col_d [3];
    logic             out_hs_q, out_hs_d, out_vs_q, out_vs_d, out_act_q, out_act_d;

    always_comb begin
        // NOTE: every _d starts as its _q, so a stalled pipeline holds and no
        // path through this block can leave a signal unassigned (no latches).
        s1_hs_d   = s1_hs_q;
        s1_vs_d   = s1_vs_q;
        s1_act_d  = s1_act_q;
        s1_mode_d = s1_mode_q;
        s2_hs_d   = s2_hs_q;
        s2_vs_d   = s2_vs_q;
        s2_act_d  = s2_act_q;
        s2_mode_d = s2_mode_q;
        out_hs_d  = out_hs_q;
        out_vs_d  = out_vs_q;
        out_act_d = out_act_q;
        for (int c = 0; c < 3; c++) begin
            s1_col_d[c]  = s1_col_q[c];
            s2_prod_d[c] = s2_prod_q[c];
            s2_rep_d[c]  = s2_rep_q[c];
            out_col_d[c] = out_col_q[c];
        end

        if (pix_en) begin
            // S1
            s1_col_d[0] = red_i;
            s1_col_d[1] = green_i;
            s1_col_d[2] = blue_i;
            s1_hs_d     = hsync_i;
            s1_vs_d     = vsync_i;
            s1_act_d    = active_i;
            s1_mode_d   = scale_mode;
            // S2
            s2_hs_d   = s1_hs_q;
            s2_vs_d   = s1_vs_q;
            s2_act_d  = s1_act_q;
            s2_mode_d = s1_mode_q;
            for (int c = 0; c < 3; c++) begin
                s2_prod_d[c] = PW'(s1_col_q[c]) * N_VAL;
                s2_rep_d[c]  = replicate(s1_col_q[c]);
            end
            // S3: blanking wins over whatever the mode produced
            out_hs_d  = s2_hs_q;
            out_vs_d  = s2_vs_q;
            out_act_d = s2_act_q;
            for (int c = 0; c < 3; c++) begin
                out_col_d[c] = s2_act_q
                             ? select_scaled(s2_mode_q, s2_prod_q[c], s2_rep_q[c])
                             : '0;
            end
        end
    end

    always_ff @(posedge clk_dot4x or posedge rst) begin
        if (rst) begin
            // NOTE: the stage arrays are cleared as well, so the pixels that
            // drain out after reset are black and inactive, not stale data.
            s1_hs_q   <= 1'b0;
            s1_vs_q   <= 1'b0;
            s1_act_q  <= 1'b0;
            s1_mode_q <= 2'd0;
            s2_hs_q   <= 1'b0;
            s2_vs_q   <= 1'b0;
            s2_act_q  <= 1'b0;
            s2_mode_q <= 2'd0;
            out_hs_q  <= 1'b0;
            out_vs_q  <= 1'b0;
            out_act_q <= 1'b0;
            for (int c = 0; c < 3; c++) begin
                s1_col_q[c]  <= '0;
                s2_prod_q[c] <= '0;
                s2_rep_q[c]  <= '0;
                out_col_q[c] <= '0;
            end
        end else begin
            // NOTE: non-blocking updates make every stage sample the previous
            // stage's old value, which is what makes this a shift pipeline.
            s1_hs_q   <= s1_hs_d;
            s1_vs_q   <= s1_vs_d;
            s1_act_q  <= s1_act_d;
            s1_mode_q <= s1_mode_d;
            s2_hs_q   <= s2_hs_d;
            s2_vs_q   <= s2_vs_d;
            s2_act_q  <= s2_act_d;
            s2_mode_q <= s2_mode_d;
            out_hs_q  <= out_hs_d;
            out_vs_q  <= out_vs_d;
            out_act_q <= out_act_d;
            for (int c = 0; c < 3; c++) begin
                s1_col_q[c]  <= s1_col_d[c];
                s2_prod_q[c] <= s2_prod_d[c];
                s2_rep_q[c]  <= s2_rep_d[c];
                out_col_q[c] <= out_col_d[c];
            end
        end
    end

    assign red_o    = out_col_q[0];
    assign green_o  = out_col_q[1];
    assign blue_o   = out_col_q[2];
    assign hsync_o  = out_hs_q;
    assign vsync_o  = out_vs_q;
    assign active_o = out_act_q;

endmodule

// File: tb/tb_rgb_scaler.sv
// -----------------------------------------------------------------------------
// tb_rgb_scaler
//
// Self-checking bench for rgb_scaler at IN_W=6/OUT_W=8, plus a second instance
// at IN_W=OUT_W=4. Expected pixels are computed from the reference formulas
// when a pixel is entered, queued, and compared when it reaches the outputs.
// -----------------------------------------------------------------------------
module tb_rgb_scaler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       pix_en;
    logic [1:0] scale_mode;
    logic [5:0] red_i, green_i, blue_i;
    logic       hsync_i, vsync_i, active_i;
    logic [7:0] red_o, green_o, blue_o;
    logic       hsync_o, vsync_o, active_o;

    logic [1:0] mode4;
    logic [3:0] r4_i, g4_i, b4_i;
    logic [3:0] r4_o, g4_o, b4_o;
    logic       hs4_o, vs4_o, act4_o;

    rgb_scaler #(.IN_W(6), .OUT_W(8)) dut (
        .clk_dot4x (clk),
        .rst       (rst),
        .pix_en    (pix_en),
        .scale_mode(scale_mode),
        .red_i     (red_i),
        .green_i   (green_i),
        .blue_i    (blue_i),
        .hsync_i   (hsync_i),
        .vsync_i   (vsync_i),
        .active_i  (active_i),
        .red_o     (red_o),
        .green_o   (green_o),
        .blue_o    (blue_o),
        .hsync_o   (hsync_o),
        .vsync_o   (vsync_o),
        .active_o  (active_o)
    );

    rgb_scaler #(.IN_W(4), .OUT_W(4)) dut4 (
        .clk_dot4x (clk),
        .rst       (rst),
        .pix_en    (1'b1),
        .scale_mode(mode4),
        .red_i     (r4_i),
        .green_i   (g4_i),
        .blue_i    (b4_i),
        .hsync_i   (1'b1),
        .vsync_i   (1'b0),
        .active_i  (1'b1),
        .red_o     (r4_o),
        .green_o   (g4_o),
        .blue_o    (b4_o),
        .hsync_o   (hs4_o),
        .vsync_o   (vs4_o),
        .active_o  (act4_o)
    );

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hs;
        logic       vs;
        logic       act;
    } pix_t;

    int   checks = 0;
    int   errors = 0;
    pix_t exp_q[$];
    pix_t last_exp;
    logic [26:0] out_vec;
    assign out_vec = {red_o, green_o, blue_o, hsync_o, vsync_o, active_o};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference scaling for 6 -> 8 bits.
    function automatic logic [7:0] scale(input logic [5:0] x, input logic [1:0] m);
        int xi;
        xi = int'(x);
        case (m)
            2'd1:    return 8'((xi * 255 + 31) / 63);
            2'd2:    return 8'((xi * 255) / 63);
            default: return {x, x[5:4]};
        endcase
    endfunction

    function automatic pix_t expect_now();
        pix_t p;
        p.r   = active_i ? scale(red_i,   scale_mode) : 8'd0;
        p.g   = active_i ? scale(green_i, scale_mode) : 8'd0;
        p.b   = active_i ? scale(blue_i,  scale_mode) : 8'd0;
        p.hs  = hsync_i;
        p.vs  = vsync_i;
        p.act = active_i;
        return p;
    endfunction

    // The two cleared stages ahead of the outputs drain as black/inactive.
    task automatic reset_model();
        exp_q.delete();
        exp_q.push_back('0);
        exp_q.push_back('0);
        last_exp = '0;
    endtask

    // One clock: a pix_en=1 edge enters a pixel and retires the oldest;
    // a pix_en=0 edge must leave the outputs untouched.
    task automatic step(input logic en, input string tag);
        pix_en = en;
        @(posedge clk);
        if (en) exp_q.push_back(expect_now());
        #1;
        if (en) last_exp = exp_q.pop_front();
        check(tag, {5'b0, out_vec}, {5'b0, last_exp});
    endtask

    task automatic set_pix(input logic [5:0] r, input logic [5:0] g, input logic [5:0] b,
                           input logic hs, input logic vs, input logic act,
                           input logic [1:0] m);
        red_i      = r;
        green_i    = g;
        blue_i     = b;
        hsync_i    = hs;
        vsync_i    = vs;
        active_i   = act;
        scale_mode = m;
    endtask

    // Hand-derived anchor points: code, mode, expected 8-bit result.
    int tv_x [14] = '{32, 32, 32, 32, 1, 1, 1, 0, 0, 0, 63, 63, 63, 63};
    int tv_m [14] = '{ 0,  1,  2,  3, 0, 1, 2, 0, 1, 2,  0,  1,  2,  3};
    int tv_e [14] = '{130, 130, 129, 130, 4, 4, 4, 0, 0, 0, 255, 255, 255, 255};

    initial begin
        logic [7:0] prev_red;
        logic [5:0] ramp;

        rst = 1'b1;
        pix_en = 1'b0;
        mode4 = 2'd0;
        r4_i = '0;
        g4_i = '0;
        b4_i = '0;
        set_pix(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        #12;
        check("reset_state", {5'b0, out_vec}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        reset_model();

        // Anchor values, each held for 3 edges so the output shows that pixel.
        for (int i = 0; i < 14; i++) begin
            set_pix(6'(tv_x[i]), 6'(tv_x[i]), 6'(tv_x[i]), 1'b0, 1'b0, 1'b1, 2'(tv_m[i]));
            repeat (3) step(1'b1, "anchor_pix");
            check($sformatf("anchor_x%0d_m%0d", tv_x[i], tv_m[i]), 32'(red_o), 32'(tv_e[i]));
        end

        // Full sweep per mode: every code via the scoreboard, red monotonic.
        prev_red = '0;
        for (int m = 0; m < 4; m++) begin
            for (int x = 0; x < 64; x++) begin
                set_pix(6'(x), 6'(63 - x), 6'(x) ^ 6'd21, x[0], x[1], 1'b1, 2'(m));
                step(1'b1, "sweep_pix");
                if (x >= 3) check("sweep_mono", {31'b0, red_o >= prev_red}, 32'd1);
                prev_red = red_o;
            end
        end

        // Alternating pix_en with a ramp; garbage is driven on stalled edges.
        ramp = 6'd0;
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) begin
                set_pix(ramp, ramp, ramp, 1'b0, 1'b1, 1'b1, 2'd1);
                ramp++;
                step(1'b1, "ramp_pix");
            end else begin
                set_pix(6'($urandom), 6'($urandom), 6'($urandom), 1'b1, 1'b0, 1'b0, 2'd2);
                step(1'b0, "ramp_hold");
            end
        end

        // Blanking with sync pass-through.
        set_pix(6'd63, 6'd63, 6'd63, 1'b1, 1'b0, 1'b0, 2'd0);
        repeat (3) step(1'b1, "blank_pix");
        check("blank_col", {8'b0, red_o, green_o, blue_o}, 32'd0);
        check("blank_hs", 32'(hsync_o), 32'd1);

        // Mode change 2 -> 1 while streaming x=32.
        set_pix(6'd32, 6'd32, 6'd32, 1'b0, 1'b0, 1'b1, 2'd2);
        repeat (4) step(1'b1, "mchg_pix");
        scale_mode = 2'd1;
        step(1'b1, "mchg_pix");
        check("mchg_old0", 32'(red_o), 32'd129);
        step(1'b1, "mchg_pix");
        check("mchg_old1", 32'(red_o), 32'd129);
        step(1'b1, "mchg_pix");
        check("mchg_new", 32'(red_o), 32'd130);

        // Random stream: mode, active and pix_en change per pixel.
        for (int i = 0; i < 150; i++) begin
            set_pix(6'($urandom), 6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 2'($urandom));
            step(1'($urandom_range(0, 1)), "rand_pix");
        end

        // Reset mid-stream: outputs clear immediately, then the pipe drains black.
        for (int i = 0; i < 5; i++) begin
            set_pix(6'($urandom), 6'($urandom), 6'($urandom), 1'b1, 1'b1, 1'b1, 2'($urandom));
            step(1'b1, "prerst_pix");
        end
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", {5'b0, out_vec}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_held", {5'b0, out_vec}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        for (int i = 0; i < 20; i++) begin
            set_pix(6'($urandom), 6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom),
                    1'b1, 2'($urandom));
            step(1'b1, "postrst_pix");
        end

        // IN_W == OUT_W: identity in every mode.
        for (int m = 0; m < 4; m++) begin
            for (int x = 0; x < 16; x++) begin
                mode4 = 2'(m);
                r4_i  = 4'(x);
                g4_i  = 4'(15 - x);
                b4_i  = 4'(x) ^ 4'd5;
                repeat (3) @(posedge clk);
                #1;
                check($sformatf("id4_m%0d_x%0d", m, x), {20'b0, r4_o, g4_o, b4_o},
                      {20'b0, 4'(x), 4'(15 - x), 4'(x) ^ 4'd5});
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
